// File: rtl/riscv_fetch_unit.sv
// Instruction fetch stage: owns the program counter, issues word requests over a
// request/grant/response handshake and queues returned words, each tagged with
// its PC, for the decoder. Redirects from execute flush everything queued and
// arrange for responses that are still in flight to be thrown away on arrival.
module riscv_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] fetched_instr_o,
  output logic [31:0] instr_pc_o,
  output logic        instr_misaligned_o
);

  // Pointer width, counter width (must hold DEPTH itself) and a wider width for
  // the issue-budget sum so it can never wrap.
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = CW + 2;
  localparam logic [SW-1:0] BUDGET = SW'(DEPTH);

  // Control state
  logic [31:0]   pc;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_count;
  logic [AW-1:0] iwr_ptr;
  logic [AW-1:0] ird_ptr;
  logic [AW-1:0] gwr_ptr;
  logic [AW-1:0] grd_ptr;
  logic          misaligned_q;

  // Storage: instruction FIFO {word, pc} and the PC FIFO of granted addresses
  logic [31:0] instr_mem [DEPTH];
  logic [31:0] ipc_mem   [DEPTH];
  logic [31:0] gpc_mem   [DEPTH];

  // Per-cycle events
  logic          grant;
  logic          resp_drop;
  logic          resp_keep;
  logic          pop;
  logic [SW-1:0] in_use;
  logic [CW-1:0] drop_redirect;
  logic [31:0]   redirect_target;

  // Issue budget: buffered entries, in-flight requests and stale responses all
  // reserve a FIFO slot. Same-cycle pops and responses earn no credit, which
  // keeps the request path free of the decoder's ready.
  always_comb begin
    in_use = SW'(fifo_count) + SW'(outstanding) + SW'(drop_count);
  end

  assign imem_req_o  = !rst_i && !redirect_i && (in_use < BUDGET);
  assign imem_addr_o = pc;

  assign grant     = imem_req_o && imem_gnt_i;
  assign resp_drop = imem_rvalid_i && (drop_count != '0);
  assign resp_keep = imem_rvalid_i && (drop_count == '0);
  assign pop       = instr_valid_o && instr_ready_i && !redirect_i;

  assign redirect_target = {redirect_pc_i[31:2], 2'b00};

  // Responses still owed to us after a redirect: every live request (including
  // any granted now), plus stale ones already pending, minus whatever arrives
  // this cycle since that response is consumed and discarded here.
  always_comb begin
    drop_redirect = drop_count - CW'(resp_drop) + outstanding + CW'(grant) - CW'(resp_keep);
  end

  // Control registers: PC, occupancy counters, pointers and misalignment pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc           <= RESET_PC;
      fifo_count   <= '0;
      outstanding  <= '0;
      drop_count   <= '0;
      iwr_ptr      <= '0;
      ird_ptr      <= '0;
      gwr_ptr      <= '0;
      grd_ptr      <= '0;
      misaligned_q <= 1'b0;
    end else if (redirect_i) begin
      pc           <= redirect_target;
      fifo_count   <= '0;
      outstanding  <= '0;
      drop_count   <= drop_redirect;
      iwr_ptr      <= '0;
      ird_ptr      <= '0;
      gwr_ptr      <= '0;
      grd_ptr      <= '0;
      misaligned_q <= |redirect_pc_i[1:0];
    end else begin
      misaligned_q <= 1'b0;
      if (grant) begin
        pc      <= pc + 32'd4;
        gwr_ptr <= gwr_ptr + AW'(1);
      end
      if (resp_drop) begin
        drop_count <= drop_count - CW'(1);
      end
      if (resp_keep) begin
        grd_ptr <= grd_ptr + AW'(1);
        iwr_ptr <= iwr_ptr + AW'(1);
      end
      if (pop) begin
        ird_ptr <= ird_ptr + AW'(1);
      end
      outstanding <= outstanding + CW'(grant) - CW'(resp_keep);
      fifo_count  <= fifo_count + CW'(resp_keep) - CW'(pop);
    end
  end

  // FIFO storage writes; contents need no reset because the pointers and counts
  // decide what is visible.
  always_ff @(posedge clk_i) begin
    if (grant) begin
      gpc_mem[gwr_ptr] <= pc;
    end
    if (resp_keep && !redirect_i) begin
      instr_mem[iwr_ptr] <= imem_rdata_i;
      ipc_mem[iwr_ptr]   <= gpc_mem[grd_ptr];
    end
  end

  // Head presentation; the word and PC read as zero whenever the FIFO is empty.
  assign instr_valid_o      = (fifo_count != '0);
  assign fetched_instr_o    = instr_valid_o ? instr_mem[ird_ptr] : 32'd0;
  assign instr_pc_o         = instr_valid_o ? ipc_mem[ird_ptr] : 32'd0;
  assign instr_misaligned_o = misaligned_q;

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Bench for riscv_fetch_unit: an in-order instruction memory with configurable
// grant rate and latency, and a scoreboard holding the PC stream the decoder
// should see (sequential words from the reset PC or the latest redirect target).
module tb_riscv_fetch_unit;

  localparam int unsigned DEPTH     = 4;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] RESET_PC2 = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] fetched_instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_misaligned_o;

  // Second instance with a reset PC near the top of the address space; it sees
  // the same inputs so its handshakes line up with the first instance.
  logic        req2;
  logic [31:0] addr2;
  logic        valid2;
  logic [31:0] instr2;
  logic [31:0] pc2;
  logic        mis2;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int unsigned gnt_pct = 100;
  int unsigned ready_pct = 100;
  int unsigned lat_min = 1;
  int unsigned lat_max = 1;
  logic [31:0] next_pc;
  logic [31:0] exp_q[$];
  mreq_t       mem_q[$];
  int          pop_cnt = 0;
  logic [31:0] last_pc = 32'd0;
  bit          chk_en = 1'b0;
  bit          phase_a = 1'b0;
  int          a_pops = 0;
  logic        mis_exp = 1'b0;

  riscv_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) u_dut (
    .clk_i(clk), .rst_i(rst_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
    .fetched_instr_o(fetched_instr_o), .instr_pc_o(instr_pc_o),
    .instr_misaligned_o(instr_misaligned_o)
  );

  riscv_fetch_unit #(.RESET_PC(RESET_PC2), .DEPTH(DEPTH)) u_dut2 (
    .clk_i(clk), .rst_i(rst_i),
    .imem_req_o(req2), .imem_addr_o(addr2), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .instr_valid_o(valid2), .instr_ready_i(instr_ready_i),
    .fetched_instr_o(instr2), .instr_pc_o(pc2),
    .instr_misaligned_o(mis2)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h5A3C_96E1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Keep enough of the expected PC stream queued for the monitor.
  task automatic refill();
    while (exp_q.size() < 16) begin
      exp_q.push_back(next_pc);
      next_pc = next_pc + 32'd4;
    end
  endtask

  // Advance one cycle: randomise ready/grant, play the memory's next response.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    redirect_i    = 1'b0;
    instr_ready_i = ($urandom_range(99) < ready_pct);
    imem_gnt_i    = ($urandom_range(99) < gnt_pct);
    if (!rst_i && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = mem_word(mem_q[0].addr);
      void'(mem_q.pop_front());
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = $urandom;
    end
    refill();
  endtask

  task automatic do_redirect(input logic [31:0] target);
    redirect_i    = 1'b1;
    redirect_pc_i = target;
    exp_q.delete();
    next_pc = {target[31:2], 2'b00};
    refill();
  endtask

  task automatic apply_reset(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      rst_i         = 1'b1;
      imem_rvalid_i = 1'b0;
      mem_q.delete();
      exp_q.delete();
      next_pc = RESET_PC;
      refill();
    end
  endtask

  task automatic wait_pop(input string name, input logic [31:0] target, input int budget);
    int start;
    bit got;
    start = pop_cnt;
    got   = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (pop_cnt != start) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s: no instruction within %0d cycles, expected pc %h", name, budget, target);
    end else begin
      check(name, last_pc, target);
    end
  endtask

  // Memory: record each granted address with the cycle its response becomes due.
  always @(negedge clk) begin
    if (!rst_i && imem_req_o && imem_gnt_i) begin
      mem_q.push_back('{addr: imem_addr_o, due: cyc + int'($urandom_range(lat_max, lat_min))});
    end
  end

  // Monitor: every accepted instruction is checked against the scoreboard head.
  always @(negedge clk) begin : monitor
    logic [31:0] e;
    if (chk_en) begin
      check1("misaligned_flag", instr_misaligned_o, mis_exp);
      if (rst_i || redirect_i) check1("req_blocked", imem_req_o, 1'b0);
      check("addr_align", {30'd0, imem_addr_o[1:0]}, 32'd0);
      if (!rst_i && !redirect_i && instr_valid_o && instr_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_empty: got pc %h with nothing expected", instr_pc_o);
        end else begin
          e = exp_q.pop_front();
          check("instr_pc", instr_pc_o, e);
          check("instr_word", fetched_instr_o, mem_word(e));
        end
        last_pc = instr_pc_o;
        pop_cnt++;
        if (phase_a && a_pops < 8) begin
          check1("dut2_valid", valid2, 1'b1);
          check("dut2_pc", pc2, RESET_PC2 + 32'(a_pops * 4));
          a_pops++;
        end
      end
    end
    mis_exp = !rst_i && redirect_i && (redirect_pc_i[1:0] != 2'b00);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int start;
    int unsigned r;
    rst_i         = 1'b1;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'd0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'd0;
    instr_ready_i = 1'b0;
    next_pc       = RESET_PC;

    // Reset values
    apply_reset(3);
    @(negedge clk);
    check1("rst_req", imem_req_o, 1'b0);
    check("rst_addr", imem_addr_o, RESET_PC);
    check1("rst_valid", instr_valid_o, 1'b0);
    check("rst_instr", fetched_instr_o, 32'd0);
    check("rst_pc", instr_pc_o, 32'd0);
    check1("rst_misaligned", instr_misaligned_o, 1'b0);
    check("rst_addr_dut2", addr2, RESET_PC2);
    check1("rst_valid_dut2", valid2, 1'b0);
    chk_en = 1'b1;

    // Release: request immediately, first instruction two cycles later (three
    // edges after the last reset cycle), then one per cycle.
    phase_a = 1'b1;
    step();
    rst_i = 1'b0;
    @(negedge clk);
    check1("first_req", imem_req_o, 1'b1);
    check("first_addr", imem_addr_o, RESET_PC);
    check("first_addr_dut2", addr2, RESET_PC2);
    check1("valid_cycle0", instr_valid_o, 1'b0);
    step();
    @(negedge clk);
    check1("valid_cycle1", instr_valid_o, 1'b0);
    step();
    @(negedge clk);
    check1("first_valid", instr_valid_o, 1'b1);
    check("first_pc", instr_pc_o, RESET_PC);
    repeat (10) begin
      step();
      @(negedge clk);
      check1("sustained_valid", instr_valid_o, 1'b1);
    end
    phase_a = 1'b0;
    check("dut2_pops", 32'(a_pops), 32'd8);

    // Decoder stall: buffer fills to DEPTH and requests stop.
    ready_pct = 0;
    repeat (10) step();
    @(negedge clk);
    check1("stall_req_low", imem_req_o, 1'b0);
    check1("stall_valid", instr_valid_o, 1'b1);
    step();
    ready_pct     = 100;
    gnt_pct       = 0;
    instr_ready_i = 1'b1;
    imem_gnt_i    = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!instr_valid_o) break;
      n++;
      step();
    end
    check("stall_buffered", 32'(n), 32'(DEPTH));

    // Redirect with several requests in flight to a slow memory.
    gnt_pct = 100;
    lat_min = 3;
    lat_max = 3;
    repeat (12) step();
    step();
    do_redirect(32'h0000_0100);
    wait_pop("redirect_slow_mem", 32'h0000_0100, 40);

    // Redirect coinciding with a response; target reaches the decoder at N+3.
    lat_min = 1;
    lat_max = 1;
    repeat (6) step();
    step();
    do_redirect(32'h0000_0200);
    @(negedge clk);
    check1("redir_req_low", imem_req_o, 1'b0);
    step();
    @(negedge clk);
    check1("redir_valid_n1", instr_valid_o, 1'b0);
    check("redir_addr_n1", imem_addr_o, 32'h0000_0200);
    step();
    @(negedge clk);
    check1("redir_valid_n2", instr_valid_o, 1'b0);
    step();
    @(negedge clk);
    check1("redir_valid_n3", instr_valid_o, 1'b1);
    check("redir_pc_n3", instr_pc_o, 32'h0000_0200);

    // Misaligned target: one-cycle flag, fetch from the aligned word.
    repeat (4) step();
    step();
    do_redirect(32'h0000_0102);
    step();
    @(negedge clk);
    check1("misaligned_pulse_hi", instr_misaligned_o, 1'b1);
    check("misaligned_fetch_addr", imem_addr_o, 32'h0000_0100);
    step();
    @(negedge clk);
    check1("misaligned_pulse_lo", instr_misaligned_o, 1'b0);
    wait_pop("misaligned_first_pc", 32'h0000_0100, 20);

    // Random traffic: sporadic grants, variable latency, stalls, redirects, resets.
    gnt_pct   = 75;
    ready_pct = 70;
    lat_min   = 1;
    lat_max   = 4;
    start     = pop_cnt;
    for (int i = 0; i < 3000; i++) begin
      step();
      r = $urandom_range(999);
      if (r < 25) begin
        do_redirect($urandom);
      end else if (r < 28) begin
        apply_reset(1 + int'($urandom_range(1)));
        step();
        rst_i = 1'b0;
      end
    end
    step();
    @(negedge clk);
    check1("random_progress", (pop_cnt - start) > 500, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_fetch_unit.md
# riscv_fetch_unit

Instruction fetch stage for the single-issue RISC-V core, directly upstream of the instruction decoder. Holds the program counter, issues word requests to instruction memory through a request/grant/response handshake, and buffers returned words in a small in-order FIFO. Presents instructions with their PC to the decoder through a valid/ready pair. Taken branch, JAL or JALR redirects from execute flush the buffer and discard in-flight responses.

## Interface

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- DEPTH, 4, instruction FIFO entries and maximum outstanding requests; power of two, ≥ 2.

Ports:
- clk_i  in  1  core clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- imem_req_o  out  1  fetch request.
- imem_addr_o  out  32  word-aligned fetch address (bits [1:0] always 0).
- imem_gnt_i  in  1  request accepted this cycle (valid only with imem_req_o).
- imem_rvalid_i  in  1  response data valid; responses in grant order, ≥ 1 cycle after grant.
- imem_rdata_i  in  32  instruction word.
- redirect_i  in  1  control-flow redirect from execute (branch taken, jal, jalr).
- redirect_pc_i  in  32  redirect target.
- instr_valid_o  out  1  FIFO head valid.
- instr_ready_i  in  1  decoder/pipeline consumes head this cycle.
- fetched_instr_o  out  32  head instruction word, to decoder fetched_instr_i.
- instr_pc_o  out  32  PC of head instruction.
- instr_misaligned_o  out  1  one-cycle pulse: redirect target had bits [1:0] ≠ 0.

## Operation

- State: pc (next address to request), FIFO of {instr, pc} with count, outstanding counter (granted, not returned), drop counter (stale responses to discard), PC FIFO of granted addresses (DEPTH entries).
- Issue rule: imem_req_o = !rst_i && !redirect_i && (fifo_count + outstanding < DEPTH), evaluated on current registered values; no credit for same-cycle pop or response.
- imem_addr_o = pc. On imem_req_o && imem_gnt_i: push pc into PC FIFO, outstanding += 1, pc += 4 (wraps 32'hFFFF_FFFC → 0).
- Address may change only on grant or redirect; the memory model accepts withdrawal of an ungranted request on redirect.
- Response: imem_rvalid_i with drop_count > 0 → drop_count −= 1, data discarded. Otherwise push {imem_rdata_i, PC FIFO head} into instruction FIFO, pop PC FIFO, outstanding −= 1.
- Pop: instr_valid_o && instr_ready_i removes head. Push and pop in the same cycle keep count unchanged; FIFO never overflows by construction of the issue rule.
- Redirect (highest priority): next cycle pc = {redirect_pc_i[31:2], 2'b00}, instruction FIFO and PC FIFO emptied, outstanding = 0, drop_count = all outstanding including one granted this cycle, minus one if a non-dropped response arrives this cycle (that response is also discarded). instr_misaligned_o = redirect_i && |redirect_pc_i[1:0], registered.
- Redirect cycle: imem_req_o = 0, no push into instruction FIFO, pop ignored (instr_valid_o is cleared next cycle anyway).
- Issue is blocked while drop_count + fifo_count + outstanding ≥ DEPTH; stale responses count against the budget.
- Reset: pc = RESET_PC, all counters 0, FIFOs empty. Reset mid-operation abandons in-flight responses; bench memory must also reset.

## Timing

- Reset values: imem_req_o 0, imem_addr_o RESET_PC, instr_valid_o 0, fetched_instr_o 0, instr_pc_o 0, instr_misaligned_o 0.
- First request: cycle after rst_i deasserts, addr RESET_PC.
- Latency: rvalid in cycle N → instr_valid_o in cycle N+1 (registered FIFO, no bypass).
- Redirect in cycle N → request to new target in cycle N+1, earliest instruction valid at N+3 with 1-cycle memory.
- Throughput: one instruction per cycle sustained with DEPTH=4 and 1-cycle memory; DEPTH=2 gives 2 per 3 cycles.
- Outputs are registered except imem_req_o, which is combinational from registers and redirect_i.

## Test plan

- Reset then 1-cycle memory, ready held 1 → PCs 0,4,8,… on instr_pc_o, first instr_valid_o 3 cycles after reset release, then one per cycle.
- instr_ready_i = 0 for 10 cycles → exactly DEPTH=4 entries buffered, imem_req_o low, no overflow; release → entries in order, no gaps or duplicates.
- Redirect to 0x100 with 3 outstanding, 3-cycle memory → 3 stale responses dropped, next valid instruction has PC 0x100.
- Redirect coinciding with rvalid and grant → both dropped; stream resumes at target.
- Redirect to 0x102 → instr_misaligned_o pulses once, fetch from 0x100.
- RESET_PC = 32'hFFFF_FFF8 → PCs FFFF_FFF8, FFFF_FFFC, 0, 4.
